isp_boot_controller: RTL and testbench

- Boot sequencer sitting between a word-stream peripheral (host link) and RISC_V_Core.
- Holds the core in reset and receives a two-word header (length, entry address) plus a program image.
- Writes the image into core instruction memory through the core's isp_write/isp_address/isp_data port.
- Releases the core and pulses start with prog_address set to the entry address.

---
 rtl/isp_boot_controller.sv | 167 ++++++++++++++++
 tb/tb_isp_boot_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_boot_controller.sv
// Boot sequencer: holds the core in reset, takes a length/entry header and an
// image from a valid/ready word stream, writes it to instruction memory, then starts the core.
module isp_boot_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 12,
  parameter int PROG_ADDR_BITS = 20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_req,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      isp_write,
  output logic [ADDRESS_BITS-1:0]   isp_address,
  output logic [DATA_WIDTH-1:0]     isp_data,
  output logic                      core_reset,
  output logic                      start,
  output logic [PROG_ADDR_BITS-1:0] prog_address,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [ADDRESS_BITS:0]     words_loaded
);

  localparam logic [DATA_WIDTH-1:0] MEM_DEPTH = DATA_WIDTH'(2 ** ADDRESS_BITS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR_LEN   = 3'd1,
    S_HDR_ENTRY = 3'd2,
    S_LOAD      = 3'd3,
    S_FLUSH     = 3'd4,
    S_START     = 3'd5,
    S_RUN       = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [ADDRESS_BITS:0]       r_len;
  logic [PROG_ADDR_BITS-1:0]   r_entry;
  logic                        r_in_ready;
  logic                        r_isp_write;
  logic [ADDRESS_BITS-1:0]     r_isp_address;
  logic [DATA_WIDTH-1:0]       r_isp_data;
  logic                        r_core_reset;
  logic                        r_start;
  logic [PROG_ADDR_BITS-1:0]   r_prog_address;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_error;
  logic [ADDRESS_BITS:0]       r_words_loaded;
  logic                        w_xfer;
  logic                        w_len_too_big;
  logic                        w_last_word;
  logic                        w_clear_count;

  assign w_xfer        = in_valid & r_in_ready;
  assign w_len_too_big = (in_data > MEM_DEPTH);
  // The word being accepted is the last one when the count after it reaches len.
  assign w_last_word   = ((r_words_loaded + {{ADDRESS_BITS{1'b0}}, 1'b1}) == r_len);
  assign w_clear_count = ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR))
                         && (w_next_state == S_HDR_LEN);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_req) w_next_state = S_HDR_LEN;
        else          w_next_state = S_IDLE;
      end
      S_HDR_LEN: begin
        if (w_xfer) w_next_state = w_len_too_big ? S_ERROR : S_HDR_ENTRY;
        else        w_next_state = S_HDR_LEN;
      end
      S_HDR_ENTRY: begin
        if (w_xfer) w_next_state = (r_len == '0) ? S_START : S_LOAD;
        else        w_next_state = S_HDR_ENTRY;
      end
      S_LOAD: begin
        if (w_xfer && w_last_word) w_next_state = S_FLUSH;
        else                       w_next_state = S_LOAD;
      end
      S_FLUSH: w_next_state = S_START;
      S_START: w_next_state = S_RUN;
      S_RUN: begin
        if (load_req) w_next_state = S_HDR_LEN;
        else          w_next_state = S_RUN;
      end
      S_ERROR: begin
        if (load_req) w_next_state = S_HDR_LEN;
        else          w_next_state = S_ERROR;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs and datapath; status flags follow the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_len          <= '0;
      r_entry        <= '0;
      r_in_ready     <= 1'b0;
      r_isp_write    <= 1'b0;
      r_isp_address  <= '0;
      r_isp_data     <= '0;
      r_core_reset   <= 1'b1;
      r_start        <= 1'b0;
      r_prog_address <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_in_ready   <= (w_next_state == S_HDR_LEN) || (w_next_state == S_HDR_ENTRY)
                      || (w_next_state == S_LOAD);
      r_busy       <= (w_next_state == S_HDR_LEN) || (w_next_state == S_HDR_ENTRY)
                      || (w_next_state == S_LOAD) || (w_next_state == S_FLUSH)
                      || (w_next_state == S_START);
      r_core_reset <= !((w_next_state == S_START) || (w_next_state == S_RUN));
      r_start      <= (w_next_state == S_START);
      r_done       <= (w_next_state == S_RUN);
      r_error      <= (w_next_state == S_ERROR);

      if ((r_state == S_HDR_LEN) && w_xfer) r_len <= in_data[ADDRESS_BITS:0];
      if ((r_state == S_HDR_ENTRY) && w_xfer) r_entry <= in_data[PROG_ADDR_BITS-1:0];
      // A zero-length image enters START straight from the entry word, before r_entry is loaded.
      if ((w_next_state == S_START) && (r_state != S_START)) begin
        r_prog_address <= (r_state == S_HDR_ENTRY) ? in_data[PROG_ADDR_BITS-1:0] : r_entry;
      end

      if ((r_state == S_LOAD) && w_xfer) begin
        r_isp_write    <= 1'b1;
        r_isp_address  <= r_words_loaded[ADDRESS_BITS-1:0];
        r_isp_data     <= in_data;
        r_words_loaded <= r_words_loaded + {{ADDRESS_BITS{1'b0}}, 1'b1};
      end else begin
        r_isp_write <= 1'b0;
        if (w_clear_count) r_words_loaded <= '0;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign isp_write    = r_isp_write;
  assign isp_address  = r_isp_address;
  assign isp_data     = r_isp_data;
  assign core_reset   = r_core_reset;
  assign start        = r_start;
  assign prog_address = r_prog_address;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_isp_boot_controller.sv
// Self-checking bench for isp_boot_controller: random images and gaps, compared
// against expectations derived from the transfer log the bench itself drives.
module tb_isp_boot_controller;
  localparam int DW = 32;
  localparam int AB = 12;
  localparam int PW = 20;
  localparam int VW = 1 + AB + DW + 1 + 1 + PW + 1 + 1 + 1 + 1 + AB + 1;
  localparam logic [VW-1:0] RST_VEC = VW'(1) << (1 + PW + 4 + AB + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          load_req;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          isp_write;
  logic [AB-1:0] isp_address;
  logic [DW-1:0] isp_data;
  logic          core_reset;
  logic          start;
  logic [PW-1:0] prog_address;
  logic          busy;
  logic          done;
  logic          error;
  logic [AB:0]   words_loaded;
  logic [VW-1:0] obs_vec;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int            xf_cyc_q[$];
  int            wr_cyc_q[$];
  logic [AB-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_dat_q[$];
  int            st_cyc_q[$];
  logic [PW-1:0] st_pa_q[$];
  logic [DW-1:0] img [0:4095];

  isp_boot_controller #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .PROG_ADDR_BITS(PW)) dut (
    .clock(clock), .reset(reset), .load_req(load_req), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .isp_write(isp_write),
    .isp_address(isp_address), .isp_data(isp_data), .core_reset(core_reset),
    .start(start), .prog_address(prog_address), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  assign obs_vec = {isp_write, isp_address, isp_data, core_reset, start, prog_address,
                    in_ready, busy, done, error, words_loaded};

  always #5 clock = ~clock;

  // Observation log sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (in_valid && in_ready) xf_cyc_q.push_back(cyc);
      if (isp_write) begin
        wr_cyc_q.push_back(cyc);
        wr_addr_q.push_back(isp_address);
        wr_dat_q.push_back(isp_data);
      end
      if (start) begin
        st_cyc_q.push_back(cyc);
        st_pa_q.push_back(prog_address);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    xf_cyc_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
    wr_dat_q.delete(); st_cyc_q.delete(); st_pa_q.delete();
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap);
    bit got;
    int t;
    got = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!got && t < 50) begin
      @(negedge clock);
      got = in_ready;
      tick();
      t++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    if (gap == 1) tick();
    else if (gap == 2) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic drive_load(input logic [DW-1:0] len_w, input logic [DW-1:0] entry_w,
                            input int n, input int gap);
    pulse_load();
    send_word(len_w, gap);
    send_word(entry_w, gap);
    for (int k = 0; k < n; k++) send_word(img[k], gap);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20 && st_cyc_q.size() == 0; i++) tick();
    repeat (2) tick();
  endtask

  task automatic test_reset();
    load_req = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      tick();
      @(negedge clock);
      checks++;
      if (obs_vec !== RST_VEC) begin
        errors++;
        $display("FAIL reset_values[%0d]: got %h, required %h", i, obs_vec, RST_VEC);
      end
      tick();
    end
    load_req = 1'b0;
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clock);
    checks++;
    if (obs_vec !== RST_VEC) begin
      errors++;
      $display("FAIL idle_values: got %h, required %h", obs_vec, RST_VEC);
    end
    tick();
  endtask

  task automatic test_image_loads();
    logic [DW-1:0] entry_w;
    int n, gap, exp_st;
    for (int s = 0; s < 10; s++) begin
      case (s)
        0, 1: begin
          n = 3; entry_w = 32'h0000_0010; gap = s;
          img[0] = 32'h0000_0013; img[1] = 32'h0050_0093; img[2] = 32'h00A0_0113;
        end
        2: begin n = 0; entry_w = 32'h0000_0040; gap = 0; end
        9: begin
          n = 4096; entry_w = $urandom; gap = 0;
          for (int k = 0; k < n; k++) img[k] = $urandom;
        end
        default: begin
          n = $urandom_range(1, 16); entry_w = $urandom; gap = 2;
          for (int k = 0; k < n; k++) img[k] = $urandom;
        end
      endcase
      clear_log();
      drive_load(DW'(n), entry_w, n, gap);
      wait_start();
      checks++;
      if (xf_cyc_q.size() !== n + 2) begin
        errors++;
        $display("FAIL load%0d_transfers: got %0d, required %0d", s, xf_cyc_q.size(), n + 2);
      end
      checks++;
      if (wr_cyc_q.size() !== n) begin
        errors++;
        $display("FAIL load%0d_write_count: got %0d, required %0d", s, wr_cyc_q.size(), n);
      end
      if (wr_cyc_q.size() == n && xf_cyc_q.size() == n + 2) begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (wr_addr_q[k] !== AB'(k) || wr_dat_q[k] !== img[k]
              || wr_cyc_q[k] !== xf_cyc_q[k + 2] + 1) begin
            errors++;
            $display("FAIL load%0d_write[%0d]: got addr %h data %h cyc %0d, required addr %h data %h cyc %0d",
                     s, k, wr_addr_q[k], wr_dat_q[k], wr_cyc_q[k], AB'(k), img[k], xf_cyc_q[k + 2] + 1);
          end
        end
      end
      exp_st = (xf_cyc_q.size() == n + 2) ? ((n == 0) ? xf_cyc_q[1] + 1 : xf_cyc_q[n + 1] + 2) : -1;
      checks++;
      if (st_cyc_q.size() !== 1 || st_cyc_q[0] !== exp_st) begin
        errors++;
        $display("FAIL load%0d_start: got %0d pulses first at cyc %0d, required 1 pulse at cyc %0d",
                 s, st_cyc_q.size(), (st_cyc_q.size() > 0) ? st_cyc_q[0] : -1, exp_st);
      end
      checks++;
      if (st_pa_q.size() < 1 || st_pa_q[0] !== entry_w[PW-1:0]) begin
        errors++;
        $display("FAIL load%0d_start_entry: got %h, required %h", s,
                 (st_pa_q.size() > 0) ? st_pa_q[0] : '0, entry_w[PW-1:0]);
      end
      @(negedge clock);
      checks++;
      if ({done, core_reset, busy, start, in_ready, error, words_loaded, prog_address}
          !== {6'b100000, (AB + 1)'(n), entry_w[PW-1:0]}) begin
        errors++;
        $display("FAIL load%0d_run_state: got d%0b cr%0b b%0b s%0b r%0b e%0b wl%0d pa%h, required d1 cr0 b0 s0 r0 e0 wl%0d pa%h",
                 s, done, core_reset, busy, start, in_ready, error, words_loaded, prog_address,
                 n, entry_w[PW-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_over_length();
    logic [DW-1:0] bad_len [2];
    bad_len[0] = 32'd4097;
    bad_len[1] = 32'hFFFF_F000;
    for (int i = 0; i < 2; i++) begin
      clear_log();
      pulse_load();
      send_word(bad_len[i], 0);
      @(negedge clock);
      checks++;
      if ({error, in_ready, core_reset, busy, done} !== 5'b10100) begin
        errors++;
        $display("FAIL overlen%0d_flags: got e%0b r%0b cr%0b b%0b d%0b, required e1 r0 cr1 b0 d0",
                 i, error, in_ready, core_reset, busy, done);
      end
      tick();
      in_valid = 1'b1;
      repeat (3) begin in_data = $urandom; tick(); end
      in_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (xf_cyc_q.size() !== 1 || wr_cyc_q.size() !== 0 || error !== 1'b1) begin
        errors++;
        $display("FAIL overlen%0d_hold: got %0d transfers %0d writes e%0b, required 1 transfer 0 writes e1",
                 i, xf_cyc_q.size(), wr_cyc_q.size(), error);
      end
      tick();
    end
    pulse_load();
    @(negedge clock);
    checks++;
    if ({error, in_ready, busy, words_loaded} !== {3'b011, (AB + 1)'(0)}) begin
      errors++;
      $display("FAIL overlen_recover: got e%0b r%0b b%0b wl%0d, required e0 r1 b1 wl0",
               error, in_ready, busy, words_loaded);
    end
    tick();
    clear_log();
    img[0] = $urandom;
    send_word(32'd1, 0);
    send_word(32'h0000_0ABC, 0);
    send_word(img[0], 0);
    wait_start();
    checks++;
    if (wr_cyc_q.size() !== 1 || st_pa_q.size() !== 1 || st_pa_q[0] !== 20'h00ABC) begin
      errors++;
      $display("FAIL overlen_reload: got %0d writes %0d starts, required 1 write 1 start at 00abc",
               wr_cyc_q.size(), st_pa_q.size());
    end
  endtask

  task automatic test_reload_and_mid_reset();
    pulse_load();
    @(negedge clock);
    checks++;
    if ({core_reset, done, busy, in_ready, words_loaded} !== {4'b1011, (AB + 1)'(0)}) begin
      errors++;
      $display("FAIL reload_from_run: got cr%0b d%0b b%0b r%0b wl%0d, required cr1 d0 b1 r1 wl0",
               core_reset, done, busy, in_ready, words_loaded);
    end
    tick();
    clear_log();
    img[0] = $urandom;
    img[1] = $urandom;
    send_word(32'd5, 0);
    send_word(32'h0000_0123, 0);
    send_word(img[0], 0);
    send_word(img[1], 0);
    reset = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (obs_vec !== RST_VEC) begin
      errors++;
      $display("FAIL midload_reset_values: got %h, required %h", obs_vec, RST_VEC);
    end
    checks++;
    if (wr_cyc_q.size() !== 2 || wr_addr_q[1] !== AB'(1)) begin
      errors++;
      $display("FAIL midload_writes: got %0d writes, required 2 ending at address 1", wr_cyc_q.size());
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    checks++;
    if ({in_ready, busy, core_reset, done} !== 4'b0010 || wr_cyc_q.size() !== 2 || st_cyc_q.size() !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: got r%0b b%0b cr%0b d%0b, %0d writes %0d starts, required r0 b0 cr1 d0 2 writes 0 starts",
               in_ready, busy, core_reset, done, wr_cyc_q.size(), st_cyc_q.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] entry_w;
    for (int r = 0; r < 2; r++) begin
      clear_log();
      entry_w = $urandom;
      for (int k = 0; k < 8; k++) img[k] = $urandom;
      drive_load(32'd8, entry_w, 8, 0);
      wait_start();
      checks++;
      if (wr_cyc_q.size() !== 8 || st_cyc_q.size() !== 1 || st_pa_q[0] !== entry_w[PW-1:0]
          || words_loaded !== 13'd8 || wr_dat_q[7] !== img[7]) begin
        errors++;
        $display("FAIL back_to_back%0d: got %0d writes %0d starts wl%0d, required 8 writes 1 start wl8 pa %h",
                 r, wr_cyc_q.size(), st_cyc_q.size(), words_loaded, entry_w[PW-1:0]);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_image_loads();
    test_over_length();
    test_reload_and_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
